// File: rtl/xm_elastic_stage_pkg.sv
// Shared definitions for the Execute->Memory elastic boundary.
//   XM_entry    : one in-flight X/M record (ctrl, data incl. dst, src, pc_jmp)
//   xm_bubble() : all-zero entry, i.e. a NOP that writes no register
//   xm_op_e     : per-edge pointer operation, encoded as {push, pop}
package xm_elastic_stage_pkg;

   localparam int unsigned XM_DEPTH_DEFAULT = 2;
   localparam int unsigned XM_CTRL_W        = 8;
   localparam int unsigned XM_DATA_W        = 97;
   localparam int unsigned XM_ADDR_W        = 5;
   localparam int unsigned XM_PC_W          = 16;

   typedef logic [XM_CTRL_W-1:0] XM_ctrl;
   typedef logic [XM_ADDR_W-1:0] RegAddr;
   typedef logic [XM_PC_W-1:0]   ProgramCounter;

   typedef struct packed {
      logic [XM_DATA_W-1:0] payload;
      RegAddr               dst;
   } M_data;

   typedef struct packed {
      XM_ctrl        ctrl;
      M_data         data;
      RegAddr        src;
      ProgramCounter pc_jmp;
   } XM_entry;

   typedef enum logic [1:0] {
      XM_OP_IDLE = 2'b00,
      XM_OP_POP  = 2'b01,
      XM_OP_PUSH = 2'b10,
      XM_OP_BOTH = 2'b11
   } xm_op_e;

   function automatic XM_entry xm_bubble();
      return '0;
   endfunction

endpackage

// File: rtl/xm_elastic_stage_ptr_ctrl.sv
// Pointer/occupancy control for the X/M circular buffer.
//   clk, rst (async, active-low), flush (synchronous squash)
//   in_valid/in_ready   : producer handshake, push = in_valid & in_ready & !flush
//   out_valid/out_ready : consumer handshake, pop  = out_valid & out_ready & !flush
//   push                : write strobe for the payload array at wr_ptr
//   wr_ptr, rd_ptr      : slot indices, wrapping at DEPTH-1 (any DEPTH >= 1)
//   count               : entries held, 0..DEPTH
module elastic_ptr_ctrl
   import xm_elastic_stage_pkg::*;
#(
   parameter  int unsigned DEPTH = XM_DEPTH_DEFAULT,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   input  logic             out_ready,
   output logic             in_ready,
   output logic             out_valid,
   output logic             push,
   output logic [PTR_W-1:0] wr_ptr,
   output logic [PTR_W-1:0] rd_ptr,
   output logic [CNT_W-1:0] count
);

   logic   pop;
   xm_op_e op;

   // Explicit wrap compare so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Handshake flags depend only on registered count: no out_ready->in_ready path.
   always_comb begin
      in_ready  = (count != CNT_W'(DEPTH));
      out_valid = (count != '0);
      push      = in_valid & in_ready & ~flush;
      pop       = out_valid & out_ready & ~flush;
      op        = xm_op_e'({push, pop});
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         count  <= '0;
         rd_ptr <= wr_ptr;
      end else begin
         unique case (op)
            XM_OP_PUSH: begin
               wr_ptr <= ptr_inc(wr_ptr);
               count  <= count + CNT_W'(1);
            end
            XM_OP_POP: begin
               rd_ptr <= ptr_inc(rd_ptr);
               count  <= count - CNT_W'(1);
            end
            XM_OP_BOTH: begin
               wr_ptr <= ptr_inc(wr_ptr);
               rd_ptr <= ptr_inc(rd_ptr);
            end
            default: ;
         endcase
      end
   end

   a_no_push_full: assert property (@(posedge clk) disable iff (!rst)
      !(push && (count == CNT_W'(DEPTH))));

   a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst)
      !(pop && (count == '0)));

   a_count_ptrs: assert property (@(posedge clk) disable iff (!rst)
      (int'(count) == ((int'(wr_ptr) + int'(DEPTH) - int'(rd_ptr)) % int'(DEPTH))) ||
      ((int'(count) == int'(DEPTH)) && (wr_ptr == rd_ptr)));

endmodule

// File: rtl/xm_elastic_stage.sv
// Execute->Memory pipeline boundary holding up to DEPTH X/M entries.
//   clk, rst (async, active-low), flush (squash held entries and current input)
//   in_valid/in_ready, in_ctrl/in_data/in_dst/in_src/in_pc_jmp : X side
//   out_valid/out_ready, out_ctrl/out_data/out_dst/out_src/out_pc_jmp : M side
//   count : entries held
// Empty slots present a bubble: out_ctrl, out_dst, out_src are 0 when !out_valid.
module xm_elastic_stage
   import xm_elastic_stage_pkg::*;
#(
   parameter  int unsigned DEPTH  = XM_DEPTH_DEFAULT,
   parameter  int unsigned CTRL_W = XM_CTRL_W,
   parameter  int unsigned DATA_W = XM_DATA_W,
   parameter  int unsigned ADDR_W = XM_ADDR_W,
   parameter  int unsigned PC_W   = XM_PC_W,
   localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic [ADDR_W-1:0] in_dst,
   input  logic [ADDR_W-1:0] in_src,
   input  logic [PC_W-1:0]   in_pc_jmp,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_dst,
   output logic [ADDR_W-1:0] out_src,
   output logic [PC_W-1:0]   out_pc_jmp,
   output logic [CNT_W-1:0]  count
);

   // Same field order as XM_entry, but sized by this instance's parameters.
   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data;
      logic [ADDR_W-1:0] dst;
      logic [ADDR_W-1:0] src;
      logic [PC_W-1:0]   pc_jmp;
   } entry_t;

   entry_t           mem [DEPTH];
   entry_t           wr_entry;
   entry_t           head;
   logic             push;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   elastic_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .out_ready (out_ready),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .push      (push),
      .wr_ptr    (wr_ptr),
      .rd_ptr    (rd_ptr),
      .count     (count)
   );

   always_comb begin
      wr_entry        = '0;
      wr_entry.ctrl   = in_ctrl;
      wr_entry.data   = in_data;
      wr_entry.dst    = in_dst;
      wr_entry.src    = in_src;
      wr_entry.pc_jmp = in_pc_jmp;
   end

   // Payload is deliberately not reset; validity is tracked by count alone.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_entry;
      end
   end

   always_comb begin
      head       = mem[rd_ptr];
      out_ctrl   = out_valid ? head.ctrl : '0;
      out_dst    = out_valid ? head.dst  : '0;
      out_src    = out_valid ? head.src  : '0;
      out_data   = head.data;
      out_pc_jmp = head.pc_jmp;
   end

endmodule

// File: tb/tb_xm_elastic_stage.sv
module tb_xm_elastic_stage;

   localparam int unsigned CW = 8;
   localparam int unsigned DW = 97;
   localparam int unsigned AW = 5;
   localparam int unsigned PW = 16;

   typedef struct {
      logic [CW-1:0] ctrl;
      logic [DW-1:0] data;
      logic [AW-1:0] dst;
      logic [AW-1:0] src;
      logic [PW-1:0] pc;
   } ent_t;

   logic clk   = 1'b0;
   logic rst   = 1'b0;
   logic flush = 1'b0;

   // Instance a: DEPTH=2, instance b: DEPTH=3
   logic          a_valid, a_ready, a_in_ready, a_out_valid;
   logic [CW-1:0] a_ctrl, a_out_ctrl;
   logic [DW-1:0] a_data, a_out_data;
   logic [AW-1:0] a_dst, a_src, a_out_dst, a_out_src;
   logic [PW-1:0] a_pc, a_out_pc;
   logic [1:0]    a_count;

   logic          b_valid, b_ready, b_in_ready, b_out_valid;
   logic [CW-1:0] b_ctrl, b_out_ctrl;
   logic [DW-1:0] b_data, b_out_data;
   logic [AW-1:0] b_dst, b_src, b_out_dst, b_out_src;
   logic [PW-1:0] b_pc, b_out_pc;
   logic [1:0]    b_count;

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;

   ent_t qa[$];
   ent_t qb[$];

   always #5 clk = ~clk;

   xm_elastic_stage u_a (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(a_valid), .in_ready(a_in_ready),
      .in_ctrl(a_ctrl), .in_data(a_data), .in_dst(a_dst), .in_src(a_src), .in_pc_jmp(a_pc),
      .out_valid(a_out_valid), .out_ready(a_ready),
      .out_ctrl(a_out_ctrl), .out_data(a_out_data), .out_dst(a_out_dst),
      .out_src(a_out_src), .out_pc_jmp(a_out_pc), .count(a_count)
   );

   xm_elastic_stage #(.DEPTH(3)) u_b (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(b_valid), .in_ready(b_in_ready),
      .in_ctrl(b_ctrl), .in_data(b_data), .in_dst(b_dst), .in_src(b_src), .in_pc_jmp(b_pc),
      .out_valid(b_out_valid), .out_ready(b_ready),
      .out_ctrl(b_out_ctrl), .out_data(b_out_data), .out_dst(b_out_dst),
      .out_src(b_out_src), .out_pc_jmp(b_out_pc), .count(b_count)
   );

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic ent_t mk(input int unsigned d);
      ent_t e;
      e.ctrl = {3'b101, 5'(d)};
      e.data = {5'(d), 60'h0F0F_0F0F_0F0F_0F0, 32'(d * 7)};
      e.dst  = 5'(d);
      e.src  = 5'(d) ^ 5'h1F;
      e.pc   = 16'h1000 + 16'(d);
      return e;
   endfunction

   task automatic drive_a(input int unsigned d);
      ent_t e = mk(d);
      a_ctrl = e.ctrl; a_data = e.data; a_dst = e.dst; a_src = e.src; a_pc = e.pc;
   endtask

   task automatic drive_b(input int unsigned d);
      ent_t e = mk(d);
      b_ctrl = e.ctrl; b_data = e.data; b_dst = e.dst; b_src = e.src; b_pc = e.pc;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Reference model: a bounded FIFO per instance, updated from the pre-edge inputs.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         qa.delete();
         qb.delete();
      end else if (flush) begin
         qa.delete();
         qb.delete();
      end else begin
         bit pa, oa, pb, ob;
         pa = a_valid && (qa.size() < 2);
         oa = a_ready && (qa.size() > 0);
         pb = b_valid && (qb.size() < 3);
         ob = b_ready && (qb.size() > 0);
         if (oa) void'(qa.pop_front());
         if (pa) qa.push_back('{a_ctrl, a_data, a_dst, a_src, a_pc});
         if (ob) void'(qb.pop_front());
         if (pb) qb.push_back('{b_ctrl, b_data, b_dst, b_src, b_pc});
      end
   end

   always @(negedge clk) begin
      chk("a_count",    128'(a_count),    128'(qa.size()));
      chk("a_in_ready", 128'(a_in_ready), 128'(qa.size() != 2));
      chk("a_out_valid",128'(a_out_valid),128'(qa.size() != 0));
      if (qa.size() != 0) begin
         chk("a_out_ctrl", 128'(a_out_ctrl), 128'(qa[0].ctrl));
         chk("a_out_data", 128'(a_out_data), 128'(qa[0].data));
         chk("a_out_dst",  128'(a_out_dst),  128'(qa[0].dst));
         chk("a_out_src",  128'(a_out_src),  128'(qa[0].src));
         chk("a_out_pc",   128'(a_out_pc),   128'(qa[0].pc));
      end else begin
         chk("a_bubble", 128'({a_out_ctrl, a_out_dst, a_out_src}), 128'(0));
      end
      chk("b_count",    128'(b_count),    128'(qb.size()));
      chk("b_in_ready", 128'(b_in_ready), 128'(qb.size() != 3));
      chk("b_out_valid",128'(b_out_valid),128'(qb.size() != 0));
      if (qb.size() != 0) begin
         chk("b_out_ctrl", 128'(b_out_ctrl), 128'(qb[0].ctrl));
         chk("b_out_data", 128'(b_out_data), 128'(qb[0].data));
         chk("b_out_dst",  128'(b_out_dst),  128'(qb[0].dst));
         chk("b_out_src",  128'(b_out_src),  128'(qb[0].src));
         chk("b_out_pc",   128'(b_out_pc),   128'(qb[0].pc));
      end else begin
         chk("b_bubble", 128'({b_out_ctrl, b_out_dst, b_out_src}), 128'(0));
      end
   end

   int unsigned wr_d [10]   = '{1, 2, 3, 4, 4, 0, 5, 6, 0, 0};
   bit          wr_v [10]   = '{1, 1, 1, 1, 1, 0, 1, 1, 0, 0};
   bit          wr_r [10]   = '{0, 0, 0, 1, 1, 1, 0, 1, 1, 1};
   int unsigned ex_hd [10]  = '{1, 1, 1, 2, 3, 4, 4, 5, 6, 0};
   int unsigned ex_cnt [10] = '{1, 2, 3, 2, 2, 1, 2, 2, 1, 0};

   initial begin
      // 1: reset held with an offer present
      a_valid = 1'b1; a_ready = 1'b0; drive_a(7);
      b_valid = 1'b0; b_ready = 1'b0; drive_b(0);
      repeat (3) @(posedge clk);
      #2;
      chk("rst_out_valid", 128'(a_out_valid), 128'(0));
      chk("rst_out_dst",   128'(a_out_dst),   128'(0));
      chk("rst_count",     128'(a_count),     128'(0));
      chk("rst_in_ready",  128'(a_in_ready),  128'(1));
      a_valid = 1'b0;
      rst = 1'b1;
      step();

      // 2: streaming, one-cycle latency, occupancy stays 1
      a_ready = 1'b1;
      for (int unsigned k = 1; k <= 8; k++) begin
         a_valid = 1'b1; drive_a(k);
         step();
         chk("stream_dst",   128'(a_out_dst), 128'(k));
         chk("stream_count", 128'(a_count),   128'(1));
      end
      a_valid = 1'b0;
      step();
      chk("stream_drain", 128'(a_count), 128'(0));

      // 3: stall until full, offer held, one pop, then acceptance
      a_ready = 1'b0;
      a_valid = 1'b1; drive_a(3); step();
      drive_a(4); step();
      chk("full_count",    128'(a_count),    128'(2));
      chk("full_in_ready", 128'(a_in_ready), 128'(0));
      drive_a(5); step();
      chk("held_count", 128'(a_count),   128'(2));
      chk("held_head",  128'(a_out_dst), 128'(3));
      a_ready = 1'b1; step();
      chk("pop3_count", 128'(a_count),   128'(1));
      chk("pop3_head",  128'(a_out_dst), 128'(4));
      a_ready = 1'b0; step();
      chk("acc5_count", 128'(a_count), 128'(2));
      a_valid = 1'b0;

      // 4: flush while full with an offer, then flush while not full
      flush = 1'b1; a_valid = 1'b1; a_ready = 1'b1; drive_a(9);
      step();
      chk("flush_count", 128'(a_count),     128'(0));
      chk("flush_valid", 128'(a_out_valid), 128'(0));
      chk("flush_ctrl",  128'(a_out_ctrl),  128'(0));
      flush = 1'b0; a_ready = 1'b0; drive_a(10);
      step();
      chk("refill_count", 128'(a_count), 128'(1));
      flush = 1'b1; drive_a(13);
      step();
      chk("flush2_count", 128'(a_count),   128'(0));
      chk("flush2_dst",   128'(a_out_dst), 128'(0));
      flush = 1'b0; a_valid = 1'b0;
      step();
      chk("flush2_gone", 128'(a_out_valid), 128'(0));

      // 5: DEPTH=3 interleavings across the 2->0 pointer wrap
      for (int i = 0; i < 10; i++) begin
         b_valid = wr_v[i]; b_ready = wr_r[i]; drive_b(wr_d[i]);
         step();
         chk("wrap_head",  128'(b_out_dst), 128'(ex_hd[i]));
         chk("wrap_count", 128'(b_count),   128'(ex_cnt[i]));
      end
      b_valid = 1'b0; b_ready = 1'b0;

      // 6: asynchronous reset between edges with two entries held
      a_ready = 1'b0; a_valid = 1'b1; drive_a(11); step();
      drive_a(12); step();
      a_valid = 1'b0;
      chk("pre_arst_count", 128'(a_count), 128'(2));
      #1;
      rst = 1'b0;
      #1;
      chk("arst_valid",    128'(a_out_valid), 128'(0));
      chk("arst_count",    128'(a_count),     128'(0));
      chk("arst_dst",      128'(a_out_dst),   128'(0));
      chk("arst_in_ready", 128'(a_in_ready),  128'(1));
      step();
      rst = 1'b1;
      step();
      chk("post_arst_count", 128'(a_count), 128'(0));
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
